// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: FSM encodings,
// header width and a small state-classification helper.
package imem_loader_pkg;

  // Length header is a 16-bit little-endian word count.
  localparam int HDR_W = 16;

  // Loader FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  // True in the states that consume stream bytes (and therefore count as busy).
  function automatic logic rx_open(input state_e s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream little-endian into 32-bit words. Raises a one-cycle
// registered word-complete flag the cycle after the 4th byte is taken.
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        fill_o,
  output logic        word_valid_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;

  // Shift new bytes in from the top so the first byte ends up in [7:0].
  always_comb begin
    word_d  = word_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    if (clr_i) begin
      cnt_d = 2'd0;
    end else if (en_i) begin
      word_d  = {byte_i, word_q[31:8]};
      cnt_d   = cnt_q + 2'd1;
      valid_d = (cnt_q == 2'd3);
    end
  end

  // Packer state; async reset drops any pending word-complete flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;
  // Combinational: the byte being accepted right now completes a word.
  assign fill_o       = en_i & ~clr_i & (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: receives a 16-bit word count then that many
// little-endian 32-bit words, writes them to memory at ascending addresses,
// and releases the core reset only once the whole image is in place.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // One extra bit so a full DEPTH_WORDS image never wraps the index.
  localparam int IDX_W = $clog2(DEPTH_WORDS) + 1;
  localparam logic [HDR_W-1:0] DEPTH_N = HDR_W'(DEPTH_WORDS);

  state_e           state_q, state_d;
  logic [HDR_W-1:0] n_q, n_d;
  logic [HDR_W-1:0] len_full;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             xfer;
  logic             last_word;
  logic             pk_clr, pk_en, pk_fill, pk_valid;
  logic [31:0]      pk_word;

  assign xfer      = rx_valid & rx_ready;
  assign pk_en     = xfer & (state_q == ST_DATA);
  assign len_full  = {rx_data, n_q[7:0]};
  // Index of the word now being filled is idx_q: each write lands at least
  // three cycles before the next word can complete.
  assign last_word = (HDR_W'(idx_q) == (n_q - HDR_W'(1)));

  byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (pk_clr),
    .en_i         (pk_en),
    .byte_i       (rx_data),
    .word_o       (pk_word),
    .fill_o       (pk_fill),
    .word_valid_o (pk_valid)
  );

  // Next-state logic: header parse, data phase and word index advance.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    pk_clr  = 1'b0;
    if (pk_valid) idx_d = idx_q + IDX_W'(1);
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_LEN_LO;
          n_d     = '0;
          idx_d   = '0;
          pk_clr  = 1'b1;
        end
      end
      ST_LEN_LO: begin
        if (xfer) begin
          n_d[7:0] = rx_data;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (xfer) begin
          n_d = len_full;
          if (len_full == '0)          state_d = ST_DONE;
          else if (len_full > DEPTH_N) state_d = ST_ERR;
          else                         state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // Leave as the final byte is taken so the closing write overlaps DONE
        // and no further byte is consumed.
        if (pk_fill && last_word) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, length and word index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
    end
  end

  // Status outputs decoded purely from the state register.
  always_comb begin
    rx_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    cpu_rst_n = 1'b0;
    if (rx_open(state_q)) begin
      rx_ready = 1'b1;
      busy     = 1'b1;
    end
    if (state_q == ST_DONE) begin
      done      = 1'b1;
      cpu_rst_n = 1'b1;
    end
    if (state_q == ST_ERR) err = 1'b1;
  end

  // Write port is zero except in the single cycle a word is issued.
  assign we    = pk_valid;
  assign wdata = pk_valid ? pk_word : 32'd0;
  assign waddr = pk_valid ? {{(32 - IDX_W - 2){1'b0}}, idx_q, 2'b00} : 32'd0;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as stimulus is
// driven and compared as the write strobe fires.
module tb_imem_loader;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready, we, cpu_rst_n, busy, done, err;
  logic [31:0] waddr, wdata;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH_WORDS(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  int          checks = 0;
  int          errors = 0;
  int          we_cnt = 0;
  int          stall_cnt = 0;
  int          we0;
  logic [63:0] sb_q[$];
  logic [63:0] sb_exp;
  logic [31:0] last_waddr = 32'd0;
  logic        last_we_done = 1'b0;
  logic [31:0] tb_mem [DEPTH];
  logic [31:0] exp_words [DEPTH];
  logic [7:0]  t6_bytes [10];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: model memory, pop scoreboard, compare address and data.
  always @(negedge clk) begin
    if (we) begin
      $display("WR addr=%08h data=%08h done=%0b", waddr, wdata, done);
      we_cnt++;
      last_waddr   = waddr;
      last_we_done = done;
      if (waddr < 32'd1024) tb_mem[waddr[9:2]] = wdata;
      if (sb_q.size() == 0) begin
        chk("we_unexpected", 64'd1, 64'd0);
      end else begin
        sb_exp = sb_q.pop_front();
        chk("waddr", {32'd0, waddr}, {32'd0, sb_exp[63:32]});
        chk("wdata", {32'd0, wdata}, {32'd0, sb_exp[31:0]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte; it is taken at the first edge where rx_ready is high.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rx_ready) ok = 1'b1;
      else stall_cnt++;
      tick();
    end
    if (!ok) chk("rx_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] w);
    sb_q.push_back({addr, w});
    for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_header(input logic [15:0] n);
    pulse_start();
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  // Wait (bounded) until every queued write has been observed.
  task automatic drain();
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) tick();
    chk("rst_outs", {58'd0, rx_ready, we, cpu_rst_n, busy, done, err}, 64'd0);
    chk("rst_wbus", {waddr, wdata}, 64'd0);
    rst_n    = 1'b1;
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    repeat (3) tick();
    chk("idle_no_autostart", {61'd0, busy, rx_ready, cpu_rst_n}, 64'd0);
    rx_valid = 1'b0;

    // Two-word load, continuous stream.
    we0 = we_cnt;
    stall_cnt = 0;
    load_header(16'd2);
    send_word(32'd0, 32'h00A00513);
    send_word(32'd4, 32'h00100593);
    chk("t1_stop_after_last", {63'd0, rx_ready}, 64'd0);
    rx_valid = 1'b0;
    drain();
    chk("t1_we_cnt", 64'(we_cnt - we0), 64'd2);
    chk("t1_status", {59'd0, done, cpu_rst_n, rx_ready, busy, err}, {59'd0, 5'b11000});
    chk("t1_done_with_last_we", {63'd0, last_we_done}, 64'd1);
    chk("t1_no_bubbles", 64'(stall_cnt), 64'd0);

    // Empty image: DONE straight after the header.
    we0 = we_cnt;
    load_header(16'd0);
    rx_valid = 1'b0;
    chk("t2_done", {61'd0, done, cpu_rst_n, busy}, {61'd0, 3'b110});
    tick();
    chk("t2_no_we", 64'(we_cnt - we0), 64'd0);
    pulse_start();
    chk("t2_restart", {61'd0, cpu_rst_n, busy, done}, {61'd0, 3'b010});

    // Oversized header (257) is rejected; already in LEN_LO from the restart.
    send_byte(8'h01);
    send_byte(8'h01);
    repeat (2) tick();
    chk("t3_err", {59'd0, err, rx_ready, cpu_rst_n, done, busy}, {59'd0, 5'b10000});
    rx_valid = 1'b0;
    chk("t3_no_we", 64'(we_cnt - we0), 64'd0);

    // Full-depth image of random words.
    we0 = we_cnt;
    stall_cnt = 0;
    load_header(16'd256);
    for (int i = 0; i < DEPTH; i++) begin
      exp_words[i] = $urandom;
      send_word(32'(i * 4), exp_words[i]);
    end
    rx_valid = 1'b0;
    drain();
    chk("t4_we_cnt", 64'(we_cnt - we0), 64'd256);
    chk("t4_last_waddr", {32'd0, last_waddr}, 64'd1020);
    chk("t4_done", {62'd0, done, cpu_rst_n}, {62'd0, 2'b11});
    chk("t4_done_with_last_we", {63'd0, last_we_done}, 64'd1);
    chk("t4_no_bubbles", 64'(stall_cnt), 64'd0);
    for (int i = 0; i < DEPTH; i++) chk("t4_readback", {32'd0, tb_mem[i]}, {32'd0, exp_words[i]});

    // Reset in the middle of word 1 of a 3-word load.
    we0 = we_cnt;
    load_header(16'd3);
    send_word(32'd0, 32'h11223344);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_outs", {58'd0, rx_ready, we, cpu_rst_n, busy, done, err}, 64'd0);
    chk("t5_rst_wbus", {waddr, wdata}, 64'd0);
    rx_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("t5_one_we", 64'(we_cnt - we0), 64'd1);
    chk("t5_idle", {60'd0, busy, done, err, rx_ready}, 64'd0);
    chk("t5_sb_empty", 64'(sb_q.size()), 64'd0);
    load_header(16'd1);
    send_word(32'd0, 32'hCAFEF00D);
    rx_valid = 1'b0;
    drain();
    chk("t5_reload_done", {62'd0, done, cpu_rst_n}, {62'd0, 2'b11});

    // rx_valid toggling every cycle, with a stray start mid-load.
    we0 = we_cnt;
    t6_bytes = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    sb_q.push_back({32'd0, 32'h00A00513});
    sb_q.push_back({32'd4, 32'h00100593});
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      send_byte(t6_bytes[k]);
      rx_valid = 1'b0;
      rx_data  = 8'hFF;
      if (k == 5) start = 1'b1;
      tick();
      start = 1'b0;
      if (k == 5) chk("t6_start_ignored", {62'd0, busy, rx_ready}, {62'd0, 2'b11});
    end
    drain();
    chk("t6_we_cnt", 64'(we_cnt - we0), 64'd2);
    chk("t6_done", {62'd0, done, cpu_rst_n}, {62'd0, 2'b11});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
